hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall sequencer for the 8-register (3-bit index, r0 hardwired zero) five-stage core.
- Runs alongside the forwarding logic and covers the hazards forwarding cannot resolve:
  - load-use dependencies: one bubble;
  - taken branches resolved in EX: flush of IF/ID and ID/EX;
  - multi-cycle data-memory accesses: full front-end freeze via a ready handshake.
- Also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

---
 rtl/hazard_stall_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the five-stage core.
// Resolves the hazards that forwarding cannot: load-use bubbles, taken-branch
// flushes, and full front-end freezes during multi-cycle data-memory accesses.
// Keeps saturating stall/flush counters and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       ID_Rs,
    input  logic [2:0]       ID_Rd,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRd,
    input  logic [2:0]       EX_Rd,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic             EX_BranchTaken,
    input  logic             MEM_Access,
    input  logic             mem_ready,
    input  logic             perf_clear,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             state_memwait,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    // Wide enough to hold MEM_TIMEOUT itself, so the compare never aliases.
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        RUN     = 1'b0,
        MEMWAIT = 1'b1
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic load_use;
    logic freeze;
    logic branch_flush;

    // Hazard detection; r0 never creates a dependency since it is hardwired zero.
    always_comb begin
        load_use = EX_MemRead && EX_RegWrite && (EX_Rd != 3'd0) &&
                   ((ID_UsesRs && (ID_Rs == EX_Rd)) ||
                    (ID_UsesRd && (ID_Rd == EX_Rd)));
        freeze       = MEM_Access && !mem_ready;
        // Branches are ignored while frozen; EX is held, so they re-evaluate on release.
        branch_flush = rst_n && !freeze && EX_BranchTaken;
    end

    // Pipeline register controls: reset forcing, then freeze > branch > load-use.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_flush   = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_flush   = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (EX_BranchTaken) begin
            // PC keeps writing so the redirect target is fetched.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Memory-wait FSM with wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state         <= RUN;
            state_memwait <= 1'b0;
            wait_cnt      <= '0;
            mem_timeout   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state         <= MEMWAIT;
                        state_memwait <= 1'b1;
                        wait_cnt      <= WAIT_W'(1);
                    end
                end
                MEMWAIT: begin
                    if (freeze) begin
                        if (wait_cnt != WAIT_MAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt == WAIT_LAST) begin
                            mem_timeout <= 1'b1;
                        end
                    end else begin
                        state         <= RUN;
                        state_memwait <= 1'b0;
                        wait_cnt      <= '0;
                    end
                end
                default: begin
                    state         <= RUN;
                    state_memwait <= 1'b0;
                    wait_cnt      <= '0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || perf_clear) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (!pc_write && stall_count != CNT_MAX) begin
                stall_count <= stall_count + 1'b1;
            end
            if (branch_flush && flush_count != CNT_MAX) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Inputs change on the falling edge; combinational controls are sampled before
// the rising edge, registered outputs just after it.
module tb_hazard_stall_ctrl;

    localparam int CNT_W = 4;

    // Control vector order: pc, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_b
    localparam logic [6:0] C_RST  = 7'b0010101;
    localparam logic [6:0] C_DEF  = 7'b1101010;
    localparam logic [6:0] C_FRZ  = 7'b0000001;
    localparam logic [6:0] C_BR   = 7'b1111110;
    localparam logic [6:0] C_LU   = 7'b0001110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       ID_Rs, ID_Rd, EX_Rd;
    logic             ID_UsesRs, ID_UsesRd;
    logic             EX_MemRead, EX_RegWrite, EX_BranchTaken;
    logic             MEM_Access, mem_ready, perf_clear;
    logic             pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
    logic             exmem_write, memwb_bubble, state_memwait, mem_timeout;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_Rs(ID_Rs), .ID_Rd(ID_Rd), .ID_UsesRs(ID_UsesRs), .ID_UsesRd(ID_UsesRd),
        .EX_Rd(EX_Rd), .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
        .EX_BranchTaken(EX_BranchTaken), .MEM_Access(MEM_Access), .mem_ready(mem_ready),
        .perf_clear(perf_clear),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
        .memwb_bubble(memwb_bubble), .state_memwait(state_memwait),
        .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [6:0] exp);
        check(tag, {25'd0, pc_write, ifid_write, ifid_flush, idex_write,
                    idex_flush, exmem_write, memwb_bubble}, {25'd0, exp});
    endtask

    task automatic idle();
        ID_Rs = 3'd0; ID_Rd = 3'd0; ID_UsesRs = 1'b0; ID_UsesRd = 1'b0;
        EX_Rd = 3'd0; EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_BranchTaken = 1'b0;
        MEM_Access = 1'b0; mem_ready = 1'b0; perf_clear = 1'b0;
    endtask

    task automatic set_load_use(input logic [2:0] rd);
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = rd;
        ID_Rs = rd; ID_UsesRs = 1'b1;
    endtask

    // Move from pre-edge sampling point to just after the rising edge.
    task automatic edge_post();
        @(posedge clk);
        #1;
    endtask

    // Move to the next falling edge where new inputs are applied.
    task automatic next_drive();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        // Reset: forced outputs, counters must not run even though pc_write=0.
        next_drive(); #1;
        chk_ctrl("reset_ctrl", C_RST);
        edge_post();
        next_drive(); #1;
        chk_ctrl("reset_ctrl_2", C_RST);
        edge_post();
        check("reset_memwait", state_memwait, 0);
        check("reset_stall", stall_count, 0);
        check("reset_flush", flush_count, 0);
        check("reset_timeout", mem_timeout, 0);

        // Idle after reset release.
        next_drive(); rst_n = 1'b1; #1;
        chk_ctrl("idle_default", C_DEF);
        edge_post();

        // Load-use on Rs: one bubble, then defaults.
        next_drive(); set_load_use(3'd3); #1;
        chk_ctrl("lu_rs", C_LU);
        edge_post();
        next_drive(); idle(); #1;
        chk_ctrl("lu_after", C_DEF);
        edge_post();
        check("lu_stall_cnt", stall_count, 1);

        // r0 destination never stalls.
        next_drive(); set_load_use(3'd0); #1;
        chk_ctrl("lu_r0", C_DEF);
        // Matching Rd that the instruction does not read.
        next_drive(); idle();
        EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_Rd = 3'd5; ID_Rd = 3'd5; #1;
        chk_ctrl("lu_rd_unused", C_DEF);
        // Same, but Rd is read: stall.
        ID_UsesRd = 1'b1; #1;
        chk_ctrl("lu_rd_used", C_LU);
        // Non-writing load does not stall.
        EX_RegWrite = 1'b0; #1;
        chk_ctrl("lu_no_regwrite", C_DEF);
        EX_RegWrite = 1'b1;
        edge_post();
        check("lu_stall_cnt2", stall_count, 2);

        // Branch overrides load-use in the same cycle.
        next_drive(); idle(); set_load_use(3'd4); EX_BranchTaken = 1'b1; #1;
        chk_ctrl("br_over_lu", C_BR);
        edge_post();
        check("br_flush_cnt", flush_count, 1);
        check("br_stall_cnt", stall_count, 2);

        // Clear counters.
        next_drive(); idle(); perf_clear = 1'b1;
        edge_post();
        check("clear_stall", stall_count, 0);
        check("clear_flush", flush_count, 0);

        // Memory wait: 3 not-ready cycles then ready; branch ignored while frozen.
        next_drive(); idle(); MEM_Access = 1'b1; EX_BranchTaken = 1'b1; #1;
        chk_ctrl("mw_c1_ctrl", C_FRZ);
        check("mw_c1_state", state_memwait, 0);
        edge_post();
        check("mw_c2_state", state_memwait, 1);
        next_drive(); #1;
        chk_ctrl("mw_c2_ctrl", C_FRZ);
        edge_post();
        next_drive(); #1;
        chk_ctrl("mw_c3_ctrl", C_FRZ);
        edge_post();
        check("mw_c4_state", state_memwait, 1);
        next_drive(); mem_ready = 1'b1; EX_BranchTaken = 1'b0; #1;
        chk_ctrl("mw_release_ctrl", C_DEF);
        edge_post();
        check("mw_run_state", state_memwait, 0);
        check("mw_stall_cnt", stall_count, 3);
        check("mw_flush_cnt", flush_count, 0);

        // Zero-wait access never leaves RUN.
        next_drive(); idle(); MEM_Access = 1'b1; mem_ready = 1'b1; #1;
        chk_ctrl("zw_ctrl", C_DEF);
        edge_post();
        check("zw_state", state_memwait, 0);

        // Timeout: sets at end of the 4th frozen cycle, sticky past release.
        next_drive(); idle(); MEM_Access = 1'b1;
        edge_post();
        next_drive();
        edge_post();
        next_drive();
        edge_post();
        check("to_after3", mem_timeout, 0);
        next_drive();
        edge_post();
        check("to_after4", mem_timeout, 1);
        next_drive(); mem_ready = 1'b1; #1;
        chk_ctrl("to_release_ctrl", C_DEF);
        edge_post();
        check("to_sticky", mem_timeout, 1);
        check("to_run_state", state_memwait, 0);

        // Reset mid-wait: forced outputs, then RUN and flag cleared.
        next_drive(); idle(); MEM_Access = 1'b1;
        edge_post();
        check("rw_in_wait", state_memwait, 1);
        next_drive(); rst_n = 1'b0; #1;
        chk_ctrl("rw_forced", C_RST);
        edge_post();
        check("rw_state", state_memwait, 0);
        check("rw_timeout", mem_timeout, 0);
        check("rw_stall", stall_count, 0);

        // Saturation: 20 load-use stalls saturate a 4-bit counter at 15.
        next_drive(); rst_n = 1'b1; idle(); set_load_use(3'd6);
        for (int i = 0; i < 20; i++) begin
            edge_post();
            next_drive();
        end
        #1;
        check("sat_stall", stall_count, 15);
        // Clear with a simultaneous stall wins.
        perf_clear = 1'b1; #1;
        chk_ctrl("sat_clear_ctrl", C_LU);
        edge_post();
        check("sat_clear", stall_count, 0);

        next_drive(); idle();
        edge_post();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
